// File: rtl/gpio_bus_master.sv
// Bus initiator for the fast GPIO register interface: queues write/read
// commands, issues one registered bus phase per command, and returns read data.
module gpio_bus_master #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int RD_WAIT = 1
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [2:0]       cmd_addr,
  input  logic [WIDTH-1:0] cmd_wdata,

  output logic             sel,
  output logic             w_en,
  output logic             rw_en,
  output logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] rdata,

  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready,

  output logic             busy,
  output logic [7:0]       err_count
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RESP
  } state_e;

  // Command FIFO
  logic             fifo_write_q [DEPTH];
  logic [2:0]       fifo_addr_q  [DEPTH];
  logic [WIDTH-1:0] fifo_wdata_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             head_write;
  logic [2:0]       head_addr;
  logic [WIDTH-1:0] head_wdata;

  // FSM and registered bus/response state
  state_e            state_q,     state_d;
  logic              sel_q,       sel_d;
  logic              w_en_q,      w_en_d;
  logic              rw_en_q,     rw_en_d;
  logic [WIDTH-1:0]  addr_q,      addr_d;
  logic [WIDTH-1:0]  wdata_q,     wdata_d;
  logic [WAIT_W-1:0] wait_q,      wait_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q,  rsp_data_d;
  logic [7:0]        err_q,       err_d;

  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = (count_q != CNT_W'(DEPTH));
  assign push       = cmd_valid && cmd_ready;

  assign head_write = fifo_write_q[rd_ptr_q];
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_wdata = fifo_wdata_q[rd_ptr_q];

  // NOTE: the entry storage has no reset; count_q alone decides which
  // entries are valid, so clearing the array would only cost flops.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write_q[wr_ptr_q] <= cmd_write;
      fifo_addr_q[wr_ptr_q]  <= cmd_addr;
      fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    sel_d       = 1'b0;
    w_en_d      = 1'b0;
    rw_en_d     = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;
    wait_d      = wait_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_addr >= 3'd6) begin
            // Illegal register: drop silently apart from the error count.
            if (err_q != 8'hFF) begin
              err_d = err_q + 8'd1;
            end
          end else if (head_write) begin
            state_d = S_WRITE;
            sel_d   = 1'b1;
            w_en_d  = 1'b1;
            addr_d  = WIDTH'(head_addr);
            wdata_d = head_wdata;
          end else begin
            state_d = S_READ;
            sel_d   = 1'b1;
            rw_en_d = 1'b1;
            addr_d  = WIDTH'(head_addr);
            wait_d  = WAIT_W'(RD_WAIT);
          end
        end
      end

      S_WRITE: begin
        state_d = S_IDLE;
      end

      S_READ: begin
        if (wait_q != '0) begin
          sel_d   = 1'b1;
          rw_en_d = 1'b1;
          addr_d  = addr_q;
          wait_d  = wait_q - WAIT_W'(1);
        end else begin
          rsp_data_d  = rdata;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      w_en_q      <= 1'b0;
      rw_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      sel_q       <= sel_d;
      w_en_q      <= w_en_d;
      rw_en_q     <= rw_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  assign sel       = sel_q;
  assign w_en      = w_en_q;
  assign rw_en     = rw_en_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err_count = err_q;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_gpio_bus_master.sv
// Self-checking bench for gpio_bus_master: a negedge monitor compares bus
// phases and responses against queues filled as commands are pushed.
module tb_gpio_bus_master;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int RD_WAIT = 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [2:0]       cmd_addr;
  logic [WIDTH-1:0] cmd_wdata;
  logic             sel, w_en, rw_en;
  logic [WIDTH-1:0] addr, wdata, rdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_ready;
  logic             busy;
  logic [7:0]       err_count;

  gpio_bus_master #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_WAIT(RD_WAIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .sel       (sel),
    .w_en      (w_en),
    .rw_en     (rw_en),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             write;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
  } bus_t;

  bus_t             bus_q[$];
  logic [WIDTH-1:0] rsp_q[$];
  int               wen_cyc_q[$];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   wen_cycles = 0;
  int   ren_cycles = 0;

  bus_t cur;
  logic have_cur  = 1'b0;
  logic sel_prev  = 1'b0;
  logic rsp_prev  = 1'b0;
  int   phase_len = 0;
  int   exp_len;
  logic [WIDTH-1:0] exp_rsp;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      have_cur  = 1'b0;
      sel_prev  = 1'b0;
      rsp_prev  = 1'b0;
      phase_len = 0;
    end else begin
      cyc++;
      if (w_en) begin
        wen_cycles++;
        wen_cyc_q.push_back(cyc);
      end
      if (rw_en) ren_cycles++;

      total++;
      if (w_en && rw_en) begin
        bad++;
        $display("FAIL strobe_overlap: w_en=%b rw_en=%b at cycle %0d", w_en, rw_en, cyc);
      end

      if (sel && !sel_prev) begin
        total++;
        if (bus_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_phase: addr=%h w_en=%b with nothing expected", addr, w_en);
          have_cur = 1'b0;
        end else begin
          cur      = bus_q.pop_front();
          have_cur = 1'b1;
        end
        phase_len = 0;
      end

      if (sel && have_cur) begin
        phase_len++;
        total++;
        if ({w_en, rw_en, addr, wdata} !== {cur.write, !cur.write, cur.addr, cur.wdata}) begin
          bad++;
          $display("FAIL bus_phase: got w=%b r=%b addr=%h wdata=%h, want w=%b r=%b addr=%h wdata=%h",
                   w_en, rw_en, addr, wdata, cur.write, !cur.write, cur.addr, cur.wdata);
        end
      end

      if (!sel) begin
        total++;
        if ({w_en, rw_en, addr, wdata} !== '0) begin
          bad++;
          $display("FAIL bus_idle: got w=%b r=%b addr=%h wdata=%h, want all zero",
                   w_en, rw_en, addr, wdata);
        end
      end

      if (!sel && sel_prev && have_cur) begin
        exp_len = cur.write ? 1 : RD_WAIT + 1;
        total++;
        if (phase_len != exp_len) begin
          bad++;
          $display("FAIL phase_len: got %0d cycles, want %0d", phase_len, exp_len);
        end
        have_cur = 1'b0;
      end

      if (rsp_valid) begin
        total++;
        if (sel) begin
          bad++;
          $display("FAIL bus_during_resp: sel=%b while rsp_valid=1", sel);
        end
      end

      if (rsp_valid && !rsp_prev) begin
        total++;
        if (rsp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rsp: rsp_data=%h with nothing expected", rsp_data);
        end else begin
          exp_rsp = rsp_q.pop_front();
          if (rsp_data !== exp_rsp) begin
            bad++;
            $display("FAIL rsp_data: got %h, want %h", rsp_data, exp_rsp);
          end
        end
      end

      sel_prev = sel;
      rsp_prev = rsp_valid;
    end
  end

  task automatic push_cmd(input logic w, input logic [2:0] a, input logic [WIDTH-1:0] d);
    bus_t e;
    int   g = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) begin
      total++;
      bad++;
      $display("FAIL push_timeout: cmd_ready=%b, want 1 within 200 cycles", cmd_ready);
    end
    if (a < 3'd6) begin
      e.write = w;
      e.addr  = WIDTH'(a);
      e.wdata = w ? d : '0;
      bus_q.push_back(e);
      if (!w) rsp_q.push_back(rdata);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || sel || rsp_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL %s_drain_timeout: busy=%b sel=%b rsp_valid=%b", tag, busy, sel, rsp_valid);
    end
    @(negedge clk); #1;
    total++;
    if (bus_q.size() != 0 || rsp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_pending: bus items=%0d rsp items=%0d, want 0 and 0", tag, bus_q.size(), rsp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    total++;
    if ({sel, w_en, rw_en} !== 3'b000) begin bad++; $display("FAIL reset_strobes: got %b want 000", {sel, w_en, rw_en}); end
    total++;
    if (addr !== '0 || wdata !== '0) begin bad++; $display("FAIL reset_bus: addr=%h wdata=%h want 0", addr, wdata); end
    total++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0) begin bad++; $display("FAIL reset_rsp: valid=%b data=%h want 0", rsp_valid, rsp_data); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++;
    if (err_count !== 8'd0) begin bad++; $display("FAIL reset_err: got %0d want 0", err_count); end
  endtask

  task automatic test_single_write();
    int w0 = wen_cycles;
    push_cmd(1'b1, 3'd1, 32'hFFFF_FFFF);
    total++;
    if (sel !== 1'b0) begin bad++; $display("FAIL write_no_same_cycle: sel=%b want 0", sel); end
    @(posedge clk); #1;
    total++;
    if ({sel, w_en, rw_en, addr, wdata} !== {3'b110, 32'd1, 32'hFFFF_FFFF}) begin
      bad++;
      $display("FAIL write_phase: sel=%b w=%b r=%b addr=%h wdata=%h want 1 1 0 1 ffffffff",
               sel, w_en, rw_en, addr, wdata);
    end
    @(posedge clk); #1;
    total++;
    if (sel !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL write_after: sel=%b busy=%b want 0 0", sel, busy); end
    wait_idle("single_write");
    total++;
    if (wen_cycles - w0 != 1) begin bad++; $display("FAIL write_wen_cycles: got %0d want 1", wen_cycles - w0); end
  endtask

  task automatic test_back_to_back();
    int w0 = wen_cycles;
    wen_cyc_q.delete();
    for (int i = 1; i <= 4; i++) push_cmd(1'b1, 3'(i), 32'h1000_0000 + 32'(i));
    for (int i = 0; i < 4; i++)  push_cmd(1'b1, 3'd0, 32'hC0DE_0000 + 32'(i));
    wait_idle("back_to_back");
    total++;
    if (wen_cycles - w0 != 8) begin bad++; $display("FAIL b2b_wen_cycles: got %0d want 8", wen_cycles - w0); end
    for (int i = 1; i < wen_cyc_q.size(); i++) begin
      total++;
      if (wen_cyc_q[i] - wen_cyc_q[i-1] != 2) begin
        bad++;
        $display("FAIL b2b_spacing: write %0d started %0d cycles after previous, want 2", i, wen_cyc_q[i] - wen_cyc_q[i-1]);
      end
    end
  endtask

  task automatic test_read();
    int r0 = ren_cycles;
    rsp_ready = 1'b0;
    rdata = 32'hA5A5_A5A5;
    push_cmd(1'b0, 3'd3, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    total++;
    if (rw_en !== 1'b1 || addr !== 32'd3) begin bad++; $display("FAIL read_start: rw_en=%b addr=%h want 1 3", rw_en, addr); end
    @(posedge clk); #1;
    total++;
    if (rw_en !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL read_hold: rw_en=%b rsp_valid=%b want 1 0", rw_en, rsp_valid); end
    @(posedge clk); #1;
    rdata = '0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hA5A5_A5A5 || sel !== 1'b0) begin
      bad++;
      $display("FAIL read_rsp: valid=%b data=%h sel=%b want 1 a5a5a5a5 0", rsp_valid, rsp_data, sel);
    end
    repeat (4) begin
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hA5A5_A5A5) begin
        bad++;
        $display("FAIL read_rsp_held: valid=%b data=%h want 1 a5a5a5a5", rsp_valid, rsp_data);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'hA5A5_A5A5) begin
      bad++;
      $display("FAIL read_consume: valid=%b data=%h want 0 a5a5a5a5", rsp_valid, rsp_data);
    end
    wait_idle("read");
    total++;
    if (ren_cycles - r0 != RD_WAIT + 1) begin bad++; $display("FAIL read_rw_cycles: got %0d want %0d", ren_cycles - r0, RD_WAIT + 1); end
  endtask

  task automatic test_fifo_full();
    bus_t e;
    rsp_ready = 1'b0;
    rdata = 32'h1234_5678;
    push_cmd(1'b0, 3'd2, '0);
    for (int i = 0; i < DEPTH; i++) push_cmd(1'b1, 3'(i + 1), 32'hF000_0000 + 32'(i));
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL full_cmd_ready: got %b want 0", cmd_ready); end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd5; cmd_wdata = 32'h0000_00EE;
    e.write = 1'b1; e.addr = 32'd5; e.wdata = 32'h0000_00EE;
    bus_q.push_back(e);
    repeat (4) begin
      @(posedge clk); #1;
      total++;
      if (cmd_ready !== 1'b0) begin bad++; $display("FAIL full_stall: cmd_ready=%b want 0", cmd_ready); end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL full_before_pop: cmd_ready=%b want 0", cmd_ready); end
    @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL full_after_pop: cmd_ready=%b want 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_idle("fifo_full");
  endtask

  task automatic test_illegal();
    int w0 = wen_cycles;
    push_cmd(1'b1, 3'd6, 32'h6666_6666);
    push_cmd(1'b0, 3'd7, '0);
    push_cmd(1'b1, 3'd2, 32'h2222_2222);
    wait_idle("illegal");
    total++;
    if (err_count !== 8'd2) begin bad++; $display("FAIL illegal_err_count: got %0d want 2", err_count); end
    total++;
    if (wen_cycles - w0 != 1) begin bad++; $display("FAIL illegal_wen_cycles: got %0d want 1", wen_cycles - w0); end
    for (int i = 0; i < 300; i++) push_cmd(i[0], 3'd6 + 3'(i[1]), 32'(i));
    wait_idle("illegal_sat");
    total++;
    if (err_count !== 8'd255) begin bad++; $display("FAIL illegal_saturate: got %0d want 255", err_count); end
  endtask

  task automatic test_reset_mid();
    int g = 0;
    int w0;
    rsp_ready = 1'b1;
    rdata = 32'h7777_7777;
    push_cmd(1'b0, 3'd5, '0);
    push_cmd(1'b1, 3'd1, 32'h1111_1111);
    push_cmd(1'b1, 3'd2, 32'h2222_2222);
    while (!rw_en && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    total++;
    if (rw_en !== 1'b1) begin bad++; $display("FAIL rst_mid_no_read: rw_en=%b want 1", rw_en); end
    reset = 1'b1;
    #1;
    bus_q.delete();
    rsp_q.delete();
    total++;
    if ({sel, w_en, rw_en} !== 3'b000 || addr !== '0) begin
      bad++;
      $display("FAIL rst_mid_bus: strobes=%b addr=%h want 000 0", {sel, w_en, rw_en}, addr);
    end
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_state: cmd_ready=%b busy=%b rsp_valid=%b want 1 0 0", cmd_ready, busy, rsp_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b0 || sel !== 1'b0) begin
        bad++;
        $display("FAIL rst_mid_quiet: rsp_valid=%b sel=%b want 0 0", rsp_valid, sel);
      end
    end
    w0 = wen_cycles;
    push_cmd(1'b1, 3'd4, 32'h0000_005A);
    wait_idle("reset_mid");
    total++;
    if (wen_cycles - w0 != 1) begin bad++; $display("FAIL rst_mid_write: wen cycles %0d want 1", wen_cycles - w0); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_read();
    test_fifo_full();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
